// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_pkg
//  Description : Shared types and default widths for the systolic tile
//                scheduler and its address generator.
//  Revision    : 1.0 - initial release
// ============================================================================
package systolic_pkg;

    // Default buffer address width and tile-count width
    localparam int unsigned c_def_addr_w = 10;
    localparam int unsigned c_def_tile_w = 8;

    // Scheduler FSM encoding
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_WAIT = 3'd2,
        ST_NEXT = 3'd3,
        ST_DONE = 3'd4
    } sched_state_e;

    // Counter width able to hold values 0..v-1, never narrower than one bit
    function automatic int unsigned cnt_w(input int unsigned v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sched_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : sched_addr_gen
//  Description : LOAD-phase beat counter and the input/weight read address
//                adders. Input addresses advance by KERNEL_SIZE per tile,
//                weight addresses restart at the weight base every tile.
//                All sums wrap modulo 2^ADDR_W.
//  Revision    : 1.0 - initial release
// ============================================================================
module sched_addr_gen
    import systolic_pkg::*;
#(
    parameter int unsigned KERNEL_SIZE = 9,
    parameter int unsigned ADDR_W      = c_def_addr_w,
    parameter int unsigned TILE_W      = c_def_tile_w
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [ADDR_W-1:0] base_w,
    input  logic [TILE_W-1:0] tile_idx,
    output logic              k_first,
    output logic              k_last,
    output logic [ADDR_W-1:0] i_addr,
    output logic [ADDR_W-1:0] w_addr
);

    localparam int unsigned      c_k_w    = cnt_w(KERNEL_SIZE);
    localparam logic [c_k_w-1:0] c_k_last = c_k_w'(KERNEL_SIZE - 1);

    logic [c_k_w-1:0]  r_k_q;
    logic [c_k_w-1:0]  w_k_d;
    logic [ADDR_W-1:0] w_tile_off;

    // Beat index within the LOAD phase; wraps to 0 after the last beat
    always_comb begin
        w_k_d = r_k_q;
        if (clr) begin
            w_k_d = '0;
        end else if (en) begin
            w_k_d = (r_k_q == c_k_last) ? '0 : r_k_q + 1'b1;
        end
    end

    // Beat index register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_k_q <= '0;
        end else begin
            r_k_q <= w_k_d;
        end
    end

    assign k_first    = (r_k_q == '0);
    assign k_last     = (r_k_q == c_k_last);
    assign w_tile_off = ADDR_W'(tile_idx * KERNEL_SIZE);
    assign i_addr     = base_i + w_tile_off + ADDR_W'(r_k_q);
    assign w_addr     = base_w + ADDR_W'(r_k_q);

endmodule
`default_nettype wire

// File: rtl/systolic_tile_sched.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_tile_sched
//  Description : Job-level sequencer in front of systolic_top. For each tile
//                of a job it streams operand read addresses, pulses the array
//                start, collects the result beats into consecutive output
//                buffer addresses and waits for the array's done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module systolic_tile_sched
    import systolic_pkg::*;
#(
    parameter int unsigned PE_ROW_NUM  = 4,
    parameter int unsigned PE_COL_NUM  = 4,
    parameter int unsigned KERNEL_SIZE = 9,
    parameter int unsigned RES_BEATS   = PE_COL_NUM,
    parameter int unsigned ADDR_W      = c_def_addr_w,
    parameter int unsigned TILE_W      = c_def_tile_w
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  job_valid,
    output logic                  job_ready,
    input  logic [TILE_W-1:0]     job_tiles,
    input  logic [ADDR_W-1:0]     job_base_i,
    input  logic [ADDR_W-1:0]     job_base_w,
    input  logic [ADDR_W-1:0]     job_base_o,
    input  logic                  abort,
    output logic                  ram_rd_en,
    output logic [ADDR_W-1:0]     ram_i_addr,
    output logic [ADDR_W-1:0]     ram_w_addr,
    output logic                  arr_start,
    input  logic                  arr_cal_done,
    input  logic [PE_ROW_NUM-1:0] arr_tvalid_res,
    output logic                  res_wr_en,
    output logic [ADDR_W-1:0]     res_wr_addr,
    output logic                  busy,
    output logic                  job_done,
    output logic [TILE_W-1:0]     tile_idx
);

    localparam int unsigned      c_b_w       = cnt_w(RES_BEATS + 1);
    localparam logic [c_b_w-1:0] c_res_beats = c_b_w'(RES_BEATS);

    sched_state_e      r_state_q,     w_state_d;
    logic [TILE_W-1:0] r_tiles_q,     w_tiles_d;
    logic [ADDR_W-1:0] r_base_i_q,    w_base_i_d;
    logic [ADDR_W-1:0] r_base_w_q,    w_base_w_d;
    logic [TILE_W-1:0] r_tile_idx_q,  w_tile_idx_d;
    logic [ADDR_W-1:0] r_o_ptr_q,     w_o_ptr_d;
    logic [c_b_w-1:0]  r_beat_cnt_q,  w_beat_cnt_d;
    logic              r_done_seen_q, w_done_seen_d;
    logic              r_job_ready_q, w_job_ready_d;
    logic              r_busy_q,      w_busy_d;
    logic              r_job_done_q,  w_job_done_d;

    logic              w_abort;
    logic              w_in_run;
    logic              w_capture;
    logic [c_b_w-1:0]  w_beats_now;
    logic              w_done_now;
    logic              w_last_tile;
    logic              w_k_first;
    logic              w_k_last;

    // Abort only matters while a job is in flight; in DONE the pulse is already due
    assign w_abort     = abort && (r_state_q != ST_IDLE) && (r_state_q != ST_DONE);
    assign w_in_run    = (r_state_q == ST_LOAD) || (r_state_q == ST_WAIT);
    assign w_capture   = w_in_run && (|arr_tvalid_res) && (r_beat_cnt_q < c_res_beats) && !w_abort;
    assign w_beats_now = r_beat_cnt_q + c_b_w'(w_capture);
    assign w_done_now  = r_done_seen_q || arr_cal_done;
    assign w_last_tile = (({1'b0, r_tile_idx_q} + 1'b1) == {1'b0, r_tiles_q});

    // Operand read strobe and start pulse; both are suppressed in the abort cycle
    assign ram_rd_en   = (r_state_q == ST_LOAD) && !w_abort;
    assign arr_start   = ram_rd_en && w_k_first;
    assign res_wr_en   = w_capture;
    assign res_wr_addr = r_o_ptr_q;
    assign job_ready   = r_job_ready_q;
    assign busy        = r_busy_q;
    assign job_done    = r_job_done_q;
    assign tile_idx    = r_tile_idx_q;

    sched_addr_gen #(
        .KERNEL_SIZE (KERNEL_SIZE),
        .ADDR_W      (ADDR_W),
        .TILE_W      (TILE_W)
    ) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .en       (ram_rd_en),
        .clr      (w_abort),
        .base_i   (r_base_i_q),
        .base_w   (r_base_w_q),
        .tile_idx (r_tile_idx_q),
        .k_first  (w_k_first),
        .k_last   (w_k_last),
        .i_addr   (ram_i_addr),
        .w_addr   (ram_w_addr)
    );

    // Next-state, result capture and per-tile bookkeeping
    always_comb begin
        w_state_d     = r_state_q;
        w_tiles_d     = r_tiles_q;
        w_base_i_d    = r_base_i_q;
        w_base_w_d    = r_base_w_q;
        w_tile_idx_d  = r_tile_idx_q;
        w_o_ptr_d     = r_o_ptr_q;
        w_beat_cnt_d  = r_beat_cnt_q;
        w_done_seen_d = r_done_seen_q;

        if (w_capture) begin
            w_o_ptr_d    = r_o_ptr_q + 1'b1;
            w_beat_cnt_d = w_beats_now;
        end
        if (w_in_run && arr_cal_done) begin
            w_done_seen_d = 1'b1;
        end

        unique case (r_state_q)
            ST_IDLE: begin
                if (job_valid) begin
                    w_tiles_d     = job_tiles;
                    w_base_i_d    = job_base_i;
                    w_base_w_d    = job_base_w;
                    w_o_ptr_d     = job_base_o;
                    w_tile_idx_d  = '0;
                    w_beat_cnt_d  = '0;
                    w_done_seen_d = 1'b0;
                    w_state_d     = (job_tiles == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_k_last) begin
                    w_state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A final beat landing in this same cycle counts toward completion
                if (w_done_now && (w_beats_now == c_res_beats)) begin
                    w_state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                w_tile_idx_d  = r_tile_idx_q + 1'b1;
                w_beat_cnt_d  = '0;
                w_done_seen_d = 1'b0;
                w_state_d     = w_last_tile ? ST_DONE : ST_LOAD;
            end
            ST_DONE: begin
                w_state_d = ST_IDLE;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase

        if (w_abort) begin
            w_state_d = ST_DONE;
        end

        w_job_ready_d = (w_state_d == ST_IDLE);
        w_busy_d      = (w_state_d != ST_IDLE);
        w_job_done_d  = (w_state_d == ST_DONE);
    end

    // State, counters, latched job fields and registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q     <= ST_IDLE;
            r_tiles_q     <= '0;
            r_base_i_q    <= '0;
            r_base_w_q    <= '0;
            r_tile_idx_q  <= '0;
            r_o_ptr_q     <= '0;
            r_beat_cnt_q  <= '0;
            r_done_seen_q <= 1'b0;
            r_job_ready_q <= 1'b1;
            r_busy_q      <= 1'b0;
            r_job_done_q  <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_tiles_q     <= w_tiles_d;
            r_base_i_q    <= w_base_i_d;
            r_base_w_q    <= w_base_w_d;
            r_tile_idx_q  <= w_tile_idx_d;
            r_o_ptr_q     <= w_o_ptr_d;
            r_beat_cnt_q  <= w_beat_cnt_d;
            r_done_seen_q <= w_done_seen_d;
            r_job_ready_q <= w_job_ready_d;
            r_busy_q      <= w_busy_d;
            r_job_done_q  <= w_job_done_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_systolic_tile_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_systolic_tile_sched
//  Description : Directed self-checking bench for systolic_tile_sched. The
//                bench plays the role of the systolic array (result beats and
//                cal_done) and checks reads/writes against queued expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_tile_sched;

    localparam int ADDR_W = 10;
    localparam int TILE_W = 8;
    localparam int KS     = 9;
    localparam int RB     = 4;
    localparam int ROWS   = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              job_valid = 1'b0;
    logic              job_ready;
    logic [TILE_W-1:0] job_tiles = '0;
    logic [ADDR_W-1:0] job_base_i = '0;
    logic [ADDR_W-1:0] job_base_w = '0;
    logic [ADDR_W-1:0] job_base_o = '0;
    logic              abort = 1'b0;
    logic              ram_rd_en;
    logic [ADDR_W-1:0] ram_i_addr;
    logic [ADDR_W-1:0] ram_w_addr;
    logic              arr_start;
    logic              arr_cal_done = 1'b0;
    logic [ROWS-1:0]   arr_tvalid_res = '0;
    logic              res_wr_en;
    logic [ADDR_W-1:0] res_wr_addr;
    logic              busy;
    logic              job_done;
    logic [TILE_W-1:0] tile_idx;

    systolic_tile_sched #(
        .PE_ROW_NUM  (ROWS),
        .PE_COL_NUM  (4),
        .KERNEL_SIZE (KS),
        .RES_BEATS   (RB),
        .ADDR_W      (ADDR_W),
        .TILE_W      (TILE_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .job_valid      (job_valid),
        .job_ready      (job_ready),
        .job_tiles      (job_tiles),
        .job_base_i     (job_base_i),
        .job_base_w     (job_base_w),
        .job_base_o     (job_base_o),
        .abort          (abort),
        .ram_rd_en      (ram_rd_en),
        .ram_i_addr     (ram_i_addr),
        .ram_w_addr     (ram_w_addr),
        .arr_start      (arr_start),
        .arr_cal_done   (arr_cal_done),
        .arr_tvalid_res (arr_tvalid_res),
        .res_wr_en      (res_wr_en),
        .res_wr_addr    (res_wr_addr),
        .busy           (busy),
        .job_done       (job_done),
        .tile_idx       (tile_idx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_mis = 0;
    int n_start = 0;
    int n_done = 0;

    logic [ADDR_W-1:0] rd_i_q[$];
    logic [ADDR_W-1:0] rd_w_q[$];
    logic [ADDR_W-1:0] wr_q[$];
    logic [ADDR_W-1:0] m_exp_i, m_exp_w, m_exp_o;
    logic [ROWS-1:0]   pat [4] = '{4'b0001, 4'b1010, 4'b1000, 4'b1111};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Scoreboard side: pop and compare every read and write the DUT issues
    always @(negedge clk) begin
        if (!rst) begin
            if (ram_rd_en) begin
                chk("rd_expected", rd_i_q.size() > 0, 1);
                if (rd_i_q.size() > 0) begin
                    m_exp_i = rd_i_q.pop_front();
                    m_exp_w = rd_w_q.pop_front();
                    chk("ram_i_addr", ram_i_addr, m_exp_i);
                    chk("ram_w_addr", ram_w_addr, m_exp_w);
                end
            end
            if (res_wr_en) begin
                chk("wr_expected", wr_q.size() > 0, 1);
                if (wr_q.size() > 0) begin
                    m_exp_o = wr_q.pop_front();
                    chk("res_wr_addr", res_wr_addr, m_exp_o);
                end
            end
            if (arr_start) n_start <= n_start + 1;
            if (job_done)  n_done  <= n_done + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_reads(input logic [ADDR_W-1:0] bi, input logic [ADDR_W-1:0] bw,
                              input int tiles, input int nk_last);
        // nk_last: number of reads issued in the final listed tile
        for (int t = 0; t < tiles; t++) begin
            for (int k = 0; k < KS; k++) begin
                if (t < tiles - 1 || k < nk_last) begin
                    rd_i_q.push_back(bi + ADDR_W'(t * KS + k));
                    rd_w_q.push_back(bw + ADDR_W'(k));
                end
            end
        end
    endtask

    task automatic push_writes(input logic [ADDR_W-1:0] bo, input int n);
        for (int j = 0; j < n; j++) wr_q.push_back(bo + ADDR_W'(j));
    endtask

    task automatic start_job(input int tiles, input logic [ADDR_W-1:0] bi,
                             input logic [ADDR_W-1:0] bw, input logic [ADDR_W-1:0] bo);
        chk("job_ready_idle", job_ready, 1);
        job_tiles  = TILE_W'(tiles);
        job_base_i = bi;
        job_base_w = bw;
        job_base_o = bo;
        job_valid  = 1'b1;
        step();
        job_valid  = 1'b0;
    endtask

    // Array model for one tile; cycle numbers are relative to the arr_start cycle
    task automatic tile_resp(input int first, input int nb, input int dc);
        int last;
        last = first + nb - 1;
        if (dc > last) last = dc;
        for (int c = 1; c <= last; c++) begin
            step();
            arr_tvalid_res = (c >= first && c < first + nb) ? pat[c % 4] : '0;
            arr_cal_done   = (c == dc);
        end
        step();
        arr_tvalid_res = '0;
        arr_cal_done   = 1'b0;
    endtask

    task automatic wait_evt(output int at, output logic is_done);
        at = -1;
        is_done = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (arr_start || job_done) begin
                at = cyc;
                is_done = job_done;
                break;
            end
            step();
        end
    endtask

    // Next tile start (or DONE) follows the WAIT exit by two cycles; WAIT begins at cycle KS
    task automatic run_tile(input int t, input int first, input int nb, input int dc, input logic last);
        int t0, at, exp_gap, lb;
        logic is_done;
        chk("tile_start", arr_start, 1);
        chk("tile_idx", tile_idx, t);
        t0 = cyc;
        lb = first + ((nb < RB) ? nb : RB) - 1;
        exp_gap = KS;
        if (lb > exp_gap) exp_gap = lb;
        if (dc > exp_gap) exp_gap = dc;
        exp_gap += 2;
        tile_resp(first, nb, dc);
        wait_evt(at, is_done);
        chk("evt_cycle", at - t0, exp_gap);
        chk("evt_is_done", is_done, last);
    endtask

    task automatic end_job(input int starts0, input int dones0, input int exp_starts);
        step();
        chk("ready_after", {job_ready, busy, job_done}, 3'b100);
        chk("rd_left", rd_i_q.size(), 0);
        chk("wr_left", wr_q.size(), 0);
        chk("start_count", n_start - starts0, exp_starts);
        chk("done_count", n_done - dones0, 1);
    endtask

    initial begin
        int s0, d0;
        #7;
        chk("reset_flags", {job_ready, busy, job_done, arr_start, ram_rd_en, res_wr_en}, 6'b100000);
        chk("reset_addr", {ram_i_addr, ram_w_addr, res_wr_addr}, 0);
        chk("reset_tile", tile_idx, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();

        // Three tiles; tile 1 carries a surplus fifth beat that must be dropped
        s0 = n_start; d0 = n_done;
        push_reads(10'd0, 10'd100, 3, KS);
        push_writes(10'd200, 12);
        start_job(3, 10'd0, 10'd100, 10'd200);
        chk("busy_run", {job_ready, busy}, 2'b01);
        run_tile(0, 5, 4, 9, 1'b0);
        run_tile(1, 5, 5, 10, 1'b0);
        run_tile(2, 3, 4, 4, 1'b1);
        end_job(s0, d0, 3);

        // Zero-tile job: straight to DONE
        s0 = n_start; d0 = n_done;
        start_job(0, 10'd5, 10'd6, 10'd7);
        chk("zero_done", {job_done, arr_start, ram_rd_en, busy}, 4'b1001);
        end_job(s0, d0, 0);

        // cal_done three cycles before the last beat, then coincident with it
        s0 = n_start; d0 = n_done;
        push_reads(10'd50, 10'd60, 2, KS);
        push_writes(10'd70, 8);
        start_job(2, 10'd50, 10'd60, 10'd70);
        run_tile(0, 12, 4, 12, 1'b0);
        run_tile(1, 12, 4, 15, 1'b1);
        end_job(s0, d0, 2);

        // Address wrap on input, weight and output buffers
        s0 = n_start; d0 = n_done;
        push_reads(10'd1020, 10'd1023, 1, KS);
        push_writes(10'd1022, 4);
        start_job(1, 10'd1020, 10'd1023, 10'd1022);
        run_tile(0, 6, 4, 10, 1'b1);
        end_job(s0, d0, 1);

        // Abort in WAIT of tile 1 after two of its beats
        s0 = n_start; d0 = n_done;
        push_reads(10'd300, 10'd400, 2, KS);
        push_writes(10'd500, 6);
        start_job(3, 10'd300, 10'd400, 10'd500);
        run_tile(0, 5, 4, 9, 1'b0);
        chk("abort_tile_idx", tile_idx, 1);
        for (int c = 1; c <= 11; c++) begin
            step();
            arr_tvalid_res = (c == 5 || c == 6) ? pat[c % 4] : '0;
        end
        abort = 1'b1;
        arr_tvalid_res = 4'b0100;
        #1;
        chk("abort_cycle", {res_wr_en, arr_start, busy}, 3'b001);
        step();
        abort = 1'b0;
        arr_tvalid_res = '0;
        chk("abort_done", job_done, 1);
        end_job(s0, d0, 2);

        // Asynchronous reset in the middle of LOAD
        push_reads(10'd10, 10'd20, 1, 3);
        start_job(2, 10'd10, 10'd20, 10'd30);
        step(); step(); step();
        d0 = n_done;
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_flags", {job_ready, busy, job_done, arr_start, ram_rd_en, res_wr_en}, 6'b100000);
        chk("midrst_addr", {ram_i_addr, ram_w_addr, res_wr_addr}, 0);
        chk("midrst_rd_left", rd_i_q.size(), 0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("midrst_no_done", n_done - d0, 0);

        // A clean job after the reset
        s0 = n_start; d0 = n_done;
        push_reads(10'd5, 10'd6, 2, KS);
        push_writes(10'd7, 8);
        start_job(2, 10'd5, 10'd6, 10'd7);
        run_tile(0, 4, 4, 11, 1'b0);
        run_tile(1, 9, 4, 9, 1'b1);
        end_job(s0, d0, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
